// File: rtl/decode_prefetch_queue.sv
// decode_prefetch_queue
//   Byte-granular circular queue between code fetch and instruction decode.
//   Fetch writes up to FETCH_BYTES bytes per cycle. Decode sees a WINDOW-byte,
//   byte-aligned view starting at the oldest queued byte, and retires 1..WINDOW
//   bytes per cycle.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   flush               drop all queued bytes, clear protocol_err
//   fetch_valid/bytes/count, fetch_ready   fetch write side
//   window, window_count                   decode view (window[0] = oldest)
//   consume_valid, consume_len             decode retire side
//   level                                  bytes currently queued
//   protocol_err                           sticky illegal-handshake flag
module decode_prefetch_queue #(
  parameter int DEPTH       = 16,
  parameter int FETCH_BYTES = 4,
  parameter int WINDOW      = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          fetch_valid,
  input  logic [8*FETCH_BYTES-1:0]      fetch_bytes,
  input  logic [2:0]                    fetch_count,
  output logic                          fetch_ready,
  output logic [WINDOW-1:0][7:0]        window,
  output logic [2:0]                    window_count,
  input  logic                          consume_valid,
  input  logic [2:0]                    consume_len,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          protocol_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [2:0]    FB3 = 3'(FETCH_BYTES);
  localparam logic [LW-1:0] WL  = LW'(WINDOW);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_err;

  logic [2:0] w_wc;
  logic       w_wr_ok, w_wr_bad, w_cs_ok, w_cs_bad;

  // Ready is judged on the registered level only; a same-cycle consume earns no credit.
  assign fetch_ready  = (LW'(DEPTH) - r_level) >= LW'(FETCH_BYTES);
  assign w_wc         = (r_level >= WL) ? 3'(WINDOW) : r_level[2:0];
  assign window_count = w_wc;
  assign level        = r_level;
  assign protocol_err = r_err;

  assign w_wr_ok  = fetch_valid & fetch_ready & ~flush & (fetch_count != 3'd0) & (fetch_count <= FB3);
  assign w_wr_bad = fetch_valid & fetch_ready & ~flush & (fetch_count > FB3);
  assign w_cs_ok  = consume_valid & ~flush & (consume_len != 3'd0) & (consume_len <= w_wc);
  assign w_cs_bad = consume_valid & ~flush & ((consume_len == 3'd0) | (consume_len > w_wc));

  // Window lanes: pointer arithmetic wraps modulo DEPTH, so the view stays
  // contiguous across the top of storage. Lanes past the valid count read 0.
  for (genvar i = 0; i < WINDOW; i++) begin : g_win
    logic [PW-1:0] w_idx;
    assign w_idx     = r_rd_ptr + PW'(i);
    assign window[i] = (3'(i) < w_wc) ? r_mem[w_idx] : 8'h00;
  end

  // Storage carries no reset; only pointers/level define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < FETCH_BYTES; i++)
        if (3'(i) < fetch_count) r_mem[r_wr_ptr + PW'(i)] <= fetch_bytes[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PW'(fetch_count);
      if (w_cs_ok) r_rd_ptr <= r_rd_ptr + PW'(consume_len);
      r_level <= r_level + (w_wr_ok ? LW'(fetch_count) : '0)
                         - (w_cs_ok ? LW'(consume_len) : '0);
      if (w_wr_bad | w_cs_bad) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_prefetch_queue.sv
module tb_decode_prefetch_queue;
  logic            clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic            fetch_valid = 1'b0, fetch_ready;
  logic [31:0]     fetch_bytes = '0;
  logic [2:0]      fetch_count = '0;
  logic [5:0][7:0] window;
  logic [2:0]      window_count;
  logic            consume_valid = 1'b0;
  logic [2:0]      consume_len = '0;
  logic [4:0]      level;
  logic            protocol_err;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mq[$];   // reference queue contents, oldest first
  bit         merr = 1'b0;

  decode_prefetch_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_bytes(fetch_bytes), .fetch_count(fetch_count),
    .fetch_ready(fetch_ready), .window(window), .window_count(window_count),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .level(level), .protocol_err(protocol_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_model(input string tag);
    int sz = mq.size();
    logic [47:0] ew = '0;
    for (int i = 0; i < 6 && i < sz; i++) ew[8*i +: 8] = mq[i];
    chk({tag, ".level"}, 64'(level), 64'(sz));
    chk({tag, ".wcount"}, 64'(window_count), 64'(sz < 6 ? sz : 6));
    chk({tag, ".window"}, 64'(window), 64'(ew));
    chk({tag, ".ready"}, 64'(fetch_ready), 64'((16 - sz) >= 4));
    chk({tag, ".err"}, 64'(protocol_err), 64'(merr));
  endtask

  // One clock: drive, update the reference model at the edge, then compare.
  task automatic cyc(input string tag, input bit fv, input logic [31:0] fb, input logic [2:0] fc,
                     input bit cv, input logic [2:0] cl, input bit fl);
    int sz, wc; bit rdy;
    fetch_valid = fv; fetch_bytes = fb; fetch_count = fc;
    consume_valid = cv; consume_len = cl; flush = fl;
    sz = mq.size(); wc = sz < 6 ? sz : 6; rdy = (16 - sz) >= 4;
    @(posedge clk); #1;
    if (fl) begin
      mq.delete(); merr = 1'b0;
    end else begin
      if (cv) begin
        if (cl >= 1 && int'(cl) <= wc) repeat (int'(cl)) void'(mq.pop_front());
        else merr = 1'b1;
      end
      if (fv && rdy) begin
        if (fc > 3'd4) merr = 1'b1;
        else for (int i = 0; i < int'(fc); i++) mq.push_back(fb[8*i +: 8]);
      end
    end
    fetch_valid = 1'b0; consume_valid = 1'b0; flush = 1'b0;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] b3;
    // Reset
    rst = 1'b1; #12; 
    chk("rst.window", 64'(window), 64'h0);
    chk("rst.wcount", 64'(window_count), 64'h0);
    chk("rst.ready", 64'(fetch_ready), 64'h1);
    chk("rst.level", 64'(level), 64'h0);
    chk("rst.err", 64'(protocol_err), 64'h0);
    rst = 1'b0; @(posedge clk); #1;

    // 1: single 4-byte write, visible next cycle
    cyc("t1", 1, 32'h9008458B, 3'd4, 0, 3'd0, 0);
    chk("t1.window", 64'(window), 64'h0000_9008_458B);
    chk("t1.wcount", 64'(window_count), 64'd4);
    chk("t1.level", 64'(level), 64'd4);

    // 2: fill to 16, then a dropped write
    cyc("t2a", 1, 32'h44332211, 3'd4, 0, 3'd0, 0);
    chk("t2.ready8", 64'(fetch_ready), 64'h1);
    cyc("t2b", 1, 32'h88776655, 3'd4, 0, 3'd0, 0);
    chk("t2.level12", 64'(level), 64'd12);
    chk("t2.ready12", 64'(fetch_ready), 64'h1);
    cyc("t2c", 1, 32'hCCBBAA99, 3'd4, 0, 3'd0, 0);
    chk("t2.level16", 64'(level), 64'd16);
    chk("t2.ready16", 64'(fetch_ready), 64'h0);
    cyc("t2d", 1, 32'hDEADBEEF, 3'd4, 0, 3'd0, 0);
    chk("t2.drop", 64'(level), 64'd16);
    chk("t2.noerr", 64'(protocol_err), 64'h0);

    // 3: at level 12, write 4 + consume 3 together
    cyc("t3a", 0, 32'h0, 3'd0, 1, 3'd4, 0);
    b3 = mq[3];
    cyc("t3b", 1, 32'h13121110, 3'd4, 1, 3'd3, 0);
    chk("t3.level", 64'(level), 64'd13);
    chk("t3.ready", 64'(fetch_ready), 64'h0);
    chk("t3.win0", 64'(window[0]), 64'(b3));

    // 6: level 9 with flush, write and consume all asserted
    cyc("t6a", 0, 32'h0, 3'd0, 1, 3'd4, 0);
    chk("t6.level9", 64'(level), 64'd9);
    cyc("t6b", 1, 32'h55555555, 3'd4, 1, 3'd2, 1);
    chk("t6.level", 64'(level), 64'd0);
    chk("t6.window", 64'(window), 64'h0);
    chk("t6.ready", 64'(fetch_ready), 64'h1);

    // 5: over-long consume is rejected and sets the sticky error
    cyc("t5a", 1, 32'h00332211, 3'd3, 0, 3'd0, 0);
    cyc("t5b", 0, 32'h0, 3'd0, 1, 3'd5, 0);
    chk("t5.level", 64'(level), 64'd3);
    chk("t5.err", 64'(protocol_err), 64'h1);
    cyc("t5c", 0, 32'h0, 3'd0, 1, 3'd1, 0);
    chk("t5.sticky", 64'(protocol_err), 64'h1);
    cyc("t5d", 0, 32'h0, 3'd0, 0, 3'd0, 1);
    chk("t5.clear", 64'(protocol_err), 64'h0);

    // 4: wrap - bring both pointers to 14, then write across the boundary
    cyc("t4a", 1, 32'h03020100, 3'd4, 0, 3'd0, 0);
    cyc("t4b", 1, 32'h07060504, 3'd4, 0, 3'd0, 0);
    cyc("t4c", 1, 32'h0B0A0908, 3'd4, 1, 3'd6, 0);
    cyc("t4d", 1, 32'h00000D0C, 3'd2, 1, 3'd6, 0);
    cyc("t4e", 0, 32'h0, 3'd0, 1, 3'd2, 0);
    chk("t4.empty", 64'(level), 64'd0);
    cyc("t4f", 1, 32'hDDCCBBAA, 3'd4, 0, 3'd0, 0);
    chk("t4.window", 64'(window), 64'h0000_DDCC_BBAA);
    cyc("t4g", 1, 32'h0000FFEE, 3'd2, 0, 3'd0, 0);
    chk("t4.window6", 64'(window), 64'hFFEE_DDCC_BBAA);

    // Edge cases: count 0 no-op, count 5 error, consume_len 0 error
    cyc("e0", 1, 32'h12345678, 3'd0, 0, 3'd0, 0);
    chk("e0.noerr", 64'(protocol_err), 64'h0);
    cyc("e5", 1, 32'h12345678, 3'd5, 0, 3'd0, 0);
    chk("e5.err", 64'(protocol_err), 64'h1);
    cyc("ef", 0, 32'h0, 3'd0, 0, 3'd0, 1);
    cyc("el0", 0, 32'h0, 3'd0, 1, 3'd0, 0);
    chk("el0.err", 64'(protocol_err), 64'h1);
    cyc("ef2", 0, 32'h0, 3'd0, 0, 3'd0, 1);

    // Random traffic against the reference queue
    for (int n = 0; n < 300; n++) begin
      cyc("rnd", $urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(1, 4)),
          $urandom_range(0, 1) == 1, 3'($urandom_range(1, 6)), $urandom_range(0, 40) == 0);
      if (protocol_err) cyc("rfl", 0, 32'h0, 3'd0, 0, 3'd0, 1);
    end

    // Async reset in the middle of a cycle with traffic pending
    cyc("pre", 1, 32'hA5A5A5A5, 3'd4, 0, 3'd0, 0);
    fetch_valid = 1'b1; fetch_bytes = 32'h11111111; fetch_count = 3'd4;
    #2 rst = 1'b1; #1;
    chk("arst.level", 64'(level), 64'd0);
    chk("arst.window", 64'(window), 64'h0);
    chk("arst.ready", 64'(fetch_ready), 64'h1);
    #2 rst = 1'b0; fetch_valid = 1'b0;
    mq.delete(); merr = 1'b0;
    @(posedge clk); #1;
    check_model("arst.post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
